// File: rtl/mempool_pkg.sv
// MemPool TCDM payload types shared by every group-to-group link.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mempool_pkg;

  // Request from a tile's master port toward a remote group's TCDM slave port.
  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [7:0]  tid;
  } tcdm_slave_req_t;

  // Response returned to the requesting tile.
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tid;
  } tcdm_master_resp_t;

  // Deepest number of requests a tile may have in flight per remote link.
  localparam int unsigned MaxTcdmOutstanding = 8;

endpackage

// File: rtl/tcdm_link_cut_pkg.sv
// Local types for the inter-group link cut: spill-buffer states and counter sizing.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package tcdm_link_cut_pkg;

  typedef enum logic [1:0] {
    FifoEmpty = 2'd0,
    FifoOne   = 2'd1,
    FifoTwo   = 2'd2
  } fifo_state_e;

  // Counter must represent 0..max_out inclusive.
  function automatic int unsigned cnt_width(int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/tcdm_link_cut_if.sv
// One direction of an inter-group TCDM link: NumPorts request and response channels.
// Ports: req/req_valid/req_ready (request), resp/resp_valid/resp_ready (response).
// Modports: slave = side receiving requests, master = side issuing requests.
interface tcdm_link_cut_if #(
  parameter int unsigned NumPorts = 4,
  parameter type req_t  = mempool_pkg::tcdm_slave_req_t,
  parameter type resp_t = mempool_pkg::tcdm_master_resp_t
);

  req_t  [NumPorts-1:0] req;
  logic  [NumPorts-1:0] req_valid;
  logic  [NumPorts-1:0] req_ready;
  resp_t [NumPorts-1:0] resp;
  logic  [NumPorts-1:0] resp_valid;
  logic  [NumPorts-1:0] resp_ready;

  modport slave (
    input  req, req_valid, resp_ready,
    output req_ready, resp, resp_valid
  );

  modport master (
    output req, req_valid, resp_ready,
    input  req_ready, resp, resp_valid
  );

endinterface

// File: rtl/tcdm_spill_fifo.sv
// Two-entry spill buffer cutting every combinational path between its two sides.
// Latency: 1 cycle push-to-valid; 1 beat/cycle sustained when the consumer is ready.
// Backpressure: push_ready_o low only when both entries are full (registered).
// Ports: clk_i, rst_i (sync, active-high); push_* in, pop_* out.
module tcdm_spill_fifo
  import tcdm_link_cut_pkg::*;
#(
  parameter type T = logic
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_valid_i,
  output logic push_ready_o,
  input  T     push_data_i,
  output logic pop_valid_o,
  input  logic pop_ready_i,
  output T     pop_data_o
);

  fifo_state_e state_q, state_d;
  T            head_q, head_d;
  T            tail_q, tail_d;
  logic        push, pop;

  assign push_ready_o = (state_q != FifoTwo);
  // Reset masks the head so a buffered beat is never seen while being discarded.
  assign pop_valid_o  = (state_q != FifoEmpty) && !rst_i;
  assign pop_data_o   = head_q;

  assign push = push_valid_i && push_ready_o;
  assign pop  = pop_valid_o && pop_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      FifoEmpty: begin
        if (push) begin
          head_d  = push_data_i;
          state_d = FifoOne;
        end
      end
      FifoOne: begin
        if (push && pop) begin
          head_d = push_data_i;
        end else if (push) begin
          tail_d  = push_data_i;
          state_d = FifoTwo;
        end else if (pop) begin
          state_d = FifoEmpty;
        end
      end
      FifoTwo: begin
        // No push possible here: ready is low.
        if (pop) begin
          head_d  = tail_q;
          state_d = FifoOne;
        end
      end
      default: state_d = FifoEmpty;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FifoEmpty;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/tcdm_link_cut.sv
// Register cut on an inter-group TCDM link with per-port outstanding-request accounting.
// Latency: 1 cycle per direction; full throughput while the far side is ready.
// Backpressure: slv req ready drops when the request buffer is full or MaxOutstanding reached.
// Ports: clk_i, rst_i; slv (requests in / responses out), mst (requests out / responses in);
//        outstanding_o per-port unanswered count; err_o sticky response-underflow flag.
module tcdm_link_cut
  import mempool_pkg::*;
  import tcdm_link_cut_pkg::*;
#(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned MaxOutstanding = MaxTcdmOutstanding,
  parameter type         req_t          = tcdm_slave_req_t,
  parameter type         resp_t         = tcdm_master_resp_t
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  tcdm_link_cut_if.slave                                     slv,
  tcdm_link_cut_if.master                                    mst,
  output logic [NumPorts-1:0][$clog2(MaxOutstanding+1)-1:0]  outstanding_o,
  output logic [NumPorts-1:0]                                err_o
);

  localparam int unsigned CntW = cnt_width(MaxOutstanding);

  req_t  [NumPorts-1:0]           req_pop_dat;
  resp_t [NumPorts-1:0]           resp_pop_dat;
  logic  [NumPorts-1:0]           req_push_rdy, req_pop_vld;
  logic  [NumPorts-1:0]           resp_push_rdy, resp_pop_vld;
  logic  [NumPorts-1:0]           cnt_full;
  logic  [NumPorts-1:0][CntW-1:0] cnt_all;
  logic  [NumPorts-1:0]           err_all;

  // cnt_full is registered-derived, so ready stays free of input paths.
  assign slv.req_ready  = req_push_rdy & ~cnt_full;
  assign mst.req_valid  = req_pop_vld;
  assign mst.req        = req_pop_dat;
  assign mst.resp_ready = resp_push_rdy;
  assign slv.resp_valid = resp_pop_vld;
  assign slv.resp       = resp_pop_dat;
  assign outstanding_o  = cnt_all;
  assign err_o          = err_all;

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic            req_hs, resp_hs;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    tcdm_spill_fifo #(.T(req_t)) i_req_fifo (
      .clk_i,
      .rst_i,
      .push_valid_i (slv.req_valid[p] & ~cnt_full[p]),
      .push_ready_o (req_push_rdy[p]),
      .push_data_i  (slv.req[p]),
      .pop_valid_o  (req_pop_vld[p]),
      .pop_ready_i  (mst.req_ready[p]),
      .pop_data_o   (req_pop_dat[p])
    );

    tcdm_spill_fifo #(.T(resp_t)) i_resp_fifo (
      .clk_i,
      .rst_i,
      .push_valid_i (mst.resp_valid[p]),
      .push_ready_o (resp_push_rdy[p]),
      .push_data_i  (mst.resp[p]),
      .pop_valid_o  (resp_pop_vld[p]),
      .pop_ready_i  (slv.resp_ready[p]),
      .pop_data_o   (resp_pop_dat[p])
    );

    // Reads and writes alike expect exactly one response each.
    assign req_hs  = slv.req_valid[p] & slv.req_ready[p];
    assign resp_hs = slv.resp_valid[p] & slv.resp_ready[p];

    assign cnt_full[p] = (cnt_q == CntW'(MaxOutstanding));
    assign cnt_all[p]  = cnt_q;
    assign err_all[p]  = err_q;

    always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      // A response with nothing outstanding has no matching request.
      if (resp_hs && (cnt_q == '0)) begin
        err_d = 1'b1;
      end
      if (req_hs && !resp_hs) begin
        cnt_d = cnt_q + 1'b1;
      end else if (resp_hs && !req_hs && (cnt_q != '0)) begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_tcdm_link_cut.sv
// Directed bench for tcdm_link_cut with a queue-level reference model checked every cycle.
module tb_tcdm_link_cut;
  import mempool_pkg::*;

  localparam int NP   = 4;
  localparam int MAXO = 8;
  localparam int CW   = $clog2(MAXO + 1);

  typedef tcdm_slave_req_t   req_t;
  typedef tcdm_master_resp_t resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tcdm_link_cut_if #(.NumPorts(NP), .req_t(req_t), .resp_t(resp_t)) slv_if ();
  tcdm_link_cut_if #(.NumPorts(NP), .req_t(req_t), .resp_t(resp_t)) mst_if ();

  logic [NP-1:0][CW-1:0] outstanding;
  logic [NP-1:0]         err;

  tcdm_link_cut #(
    .NumPorts(NP), .MaxOutstanding(MAXO), .req_t(req_t), .resp_t(resp_t)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .slv           (slv_if),
    .mst           (mst_if),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int idx, logic [127:0] act, logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s[%0d] at cycle %0d: got %0h, expected %0h", name, idx, cyc, act, exp);
    end
  endfunction

  function automatic req_t mk_req(int i);
    req_t r;
    r.addr = 32'h1000_0000 + 32'(i * 4);
    r.wen  = i[0];
    r.be   = 4'hF;
    r.data = 32'hA5A5_0000 | 32'(i);
    r.tid  = 8'(i);
    return r;
  endfunction

  function automatic resp_t mk_resp(int i);
    resp_t r;
    r.data = 32'h5A5A_0000 | 32'(i);
    r.tid  = 8'(i);
    return r;
  endfunction

  // Reference model: each buffer is a list of at most two pending beats.
  req_t  mreq   [NP][2];
  int    mreq_n [NP];
  resp_t mrsp   [NP][2];
  int    mrsp_n [NP];
  int    mcnt   [NP];
  bit    merr   [NP];
  bit    rq_in, rq_out, rs_in, rs_out;

  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        mreq_n[p] = 0; mrsp_n[p] = 0; mcnt[p] = 0; merr[p] = 1'b0;
      end else begin
        rq_in  = slv_if.req_valid[p] && (mreq_n[p] < 2) && (mcnt[p] != MAXO);
        rq_out = mst_if.req_ready[p] && (mreq_n[p] > 0);
        rs_in  = mst_if.resp_valid[p] && (mrsp_n[p] < 2);
        rs_out = slv_if.resp_ready[p] && (mrsp_n[p] > 0);
        if (rq_out) begin mreq[p][0] = mreq[p][1]; mreq_n[p]--; end
        if (rq_in)  begin mreq[p][mreq_n[p]] = slv_if.req[p]; mreq_n[p]++; end
        if (rs_out) begin mrsp[p][0] = mrsp[p][1]; mrsp_n[p]--; end
        if (rs_in)  begin mrsp[p][mrsp_n[p]] = mst_if.resp[p]; mrsp_n[p]++; end
        if (rs_out && mcnt[p] == 0) merr[p] = 1'b1;
        if (rq_in && !rs_out) mcnt[p]++;
        else if (rs_out && !rq_in && mcnt[p] > 0) mcnt[p]--;
      end
    end
  end

  // Delivered-beat log plus the every-cycle comparison against the model.
  req_t dlv     [NP][32];
  int   dlv_cyc [NP][32];
  int   dlv_n   [NP];
  int   rsp_dlv [NP];
  bit   exp_v;

  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int p = 0; p < NP; p++) begin
        exp_v = (mreq_n[p] > 0) && !rst;
        check("mst_req_valid", p, mst_if.req_valid[p], exp_v);
        if (exp_v) check("mst_req_dat", p, mst_if.req[p], mreq[p][0]);
        check("slv_req_ready", p, slv_if.req_ready[p], (mreq_n[p] < 2) && (mcnt[p] != MAXO));
        exp_v = (mrsp_n[p] > 0) && !rst;
        check("slv_resp_valid", p, slv_if.resp_valid[p], exp_v);
        if (exp_v) check("slv_resp_dat", p, slv_if.resp[p], mrsp[p][0]);
        check("mst_resp_ready", p, mst_if.resp_ready[p], mrsp_n[p] < 2);
        check("outstanding", p, outstanding[p], mcnt[p]);
        check("err", p, err[p], merr[p]);
        if (mst_if.req_valid[p] === 1'b1 && mst_if.req_ready[p] === 1'b1) begin
          if (dlv_n[p] < 32) begin
            dlv[p][dlv_n[p]]     = mst_if.req[p];
            dlv_cyc[p][dlv_n[p]] = cyc;
          end
          dlv_n[p]++;
        end
        if (slv_if.resp_valid[p] === 1'b1 && slv_if.resp_ready[p] === 1'b1) rsp_dlv[p]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int acc_n, rsp_sent, a, b, base_q, base_r;
  int acc_cyc [16];
  bit resp_on, h1, h2;

  initial begin
    for (int p = 0; p < NP; p++) begin dlv_n[p] = 0; rsp_dlv[p] = 0; end
    slv_if.req        = '0;
    slv_if.req_valid  = '0;
    slv_if.resp_ready = '1;
    mst_if.req_ready  = '1;
    mst_if.resp       = '0;
    mst_if.resp_valid = '0;

    // Reset: 2-cycle pulse.
    step(); step();
    rst = 1'b0;
    check("rst_mst_req_valid", 0, mst_if.req_valid, 4'h0);
    check("rst_slv_resp_valid", 0, slv_if.resp_valid, 4'h0);
    check("rst_slv_req_ready", 0, slv_if.req_ready, 4'hF);
    check("rst_mst_resp_ready", 0, mst_if.resp_ready, 4'hF);
    check("rst_outstanding", 0, outstanding, '0);
    check("rst_err", 0, err, 4'h0);

    // Streaming on port 0: 8 fill the outstanding window, then responses free it.
    acc_n = 0; rsp_sent = 0; resp_on = 1'b0;
    for (int t = 0; t < 200 && rsp_dlv[0] < 16; t++) begin
      slv_if.req_valid[0]  = (acc_n < 16);
      slv_if.req[0]        = mk_req(acc_n);
      mst_if.resp_valid[0] = resp_on && (rsp_sent < dlv_n[0]);
      mst_if.resp[0]       = mk_resp(rsp_sent);
      h1 = slv_if.req_valid[0] && slv_if.req_ready[0];
      h2 = mst_if.resp_valid[0] && mst_if.resp_ready[0];
      if (h1) acc_cyc[acc_n] = cyc;
      step();
      if (h1) acc_n++;
      if (h2) rsp_sent++;
      if (!resp_on && acc_n == 8) begin
        check("stream_cnt_at_max", 0, outstanding[0], 8);
        check("stream_stall", 0, slv_if.req_ready[0], 1'b0);
        resp_on = 1'b1;
      end
    end
    slv_if.req_valid[0]  = 1'b0;
    mst_if.resp_valid[0] = 1'b0;
    step();
    check("stream_accepted", 0, acc_n, 16);
    check("stream_delivered", 0, dlv_n[0], 16);
    check("stream_resp_done", 0, rsp_dlv[0], 16);
    for (int i = 0; i < 16; i++) begin
      check("stream_order_tid", i, dlv[0][i].tid, i);
      check("stream_latency", i, dlv_cyc[0][i] - acc_cyc[i], 1);
    end
    check("stream_cnt_end", 0, outstanding[0], 0);

    // Backpressure on port 1: A,B,C offered while the far side stalls.
    mst_if.req_ready[1] = 1'b0;
    a = 0;
    for (int t = 0; t < 6; t++) begin
      slv_if.req_valid[1] = (a < 3);
      slv_if.req[1]       = mk_req(100 + a);
      h1 = slv_if.req_valid[1] && slv_if.req_ready[1];
      step();
      if (h1) begin
        a++;
        if (a == 2) check("bp_ready_drop", 1, slv_if.req_ready[1], 1'b0);
      end
    end
    check("bp_accepted", 1, a, 2);
    mst_if.req_ready[1] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      slv_if.req_valid[1] = (a < 3);
      slv_if.req[1]       = mk_req(100 + a);
      h1 = slv_if.req_valid[1] && slv_if.req_ready[1];
      step();
      if (h1) a++;
    end
    slv_if.req_valid[1] = 1'b0;
    check("bp_delivered", 1, dlv_n[1], 3);
    check("bp_first_A", 1, dlv[1][0].tid, 8'd100);
    check("bp_second_B", 1, dlv[1][1].tid, 8'd101);
    check("bp_third_C_data", 1, dlv[1][2].data, 32'hA5A5_0066);

    // Outstanding limit on port 3.
    a = 0;
    for (int t = 0; t < 30 && a < 8; t++) begin
      slv_if.req_valid[3] = 1'b1;
      slv_if.req[3]       = mk_req(30 + a);
      h1 = slv_if.req_ready[3];
      step();
      if (h1) a++;
    end
    step(); step();
    check("lim_cnt", 3, outstanding[3], 8);
    check("lim_ready", 3, slv_if.req_ready[3], 1'b0);
    mst_if.resp_valid[3] = 1'b1;
    mst_if.resp[3]       = mk_resp(77);
    step();
    mst_if.resp_valid[3] = 1'b0;
    for (int t = 0; t < 6; t++) step();
    slv_if.req_valid[3] = 1'b0;
    check("lim_cnt_after", 3, outstanding[3], 8);
    check("lim_ready_after", 3, slv_if.req_ready[3], 1'b0);
    check("lim_resp_seen", 3, rsp_dlv[3], 1);
    check("lim_req_refill", 3, dlv_n[3], 9);

    // Underflow on port 2.
    mst_if.resp_valid[2] = 1'b1;
    mst_if.resp[2]       = mk_resp(200);
    step();
    mst_if.resp_valid[2] = 1'b0;
    step(); step(); step();
    check("uf_err", 2, err, 4'b0100);
    check("uf_cnt", 2, outstanding[2], 0);
    for (int t = 0; t < 5; t++) step();
    check("uf_err_sticky", 2, err, 4'b0100);

    // Mid-operation reset with both port-1 buffers full.
    mst_if.req_ready[1]  = 1'b0;
    slv_if.resp_ready[1] = 1'b0;
    a = 0; b = 0;
    for (int t = 0; t < 10 && (a < 2 || b < 2); t++) begin
      slv_if.req_valid[1]  = (a < 2);
      slv_if.req[1]        = mk_req(50 + a);
      mst_if.resp_valid[1] = (b < 2);
      mst_if.resp[1]       = mk_resp(50 + b);
      h1 = slv_if.req_valid[1] && slv_if.req_ready[1];
      h2 = mst_if.resp_valid[1] && mst_if.resp_ready[1];
      step();
      if (h1) a++;
      if (h2) b++;
    end
    slv_if.req_valid[1]  = 1'b0;
    mst_if.resp_valid[1] = 1'b0;
    check("mr_req_full", 1, slv_if.req_ready[1], 1'b0);
    check("mr_resp_full", 1, mst_if.resp_ready[1], 1'b0);
    check("mr_cnt_before", 1, outstanding[1], 5);
    base_q = dlv_n[1];
    base_r = rsp_dlv[1];
    rst = 1'b1;
    mst_if.req_ready[1]  = 1'b1;
    slv_if.resp_ready[1] = 1'b1;
    step();
    check("mr_req_empty", 1, slv_if.req_ready[1], 1'b1);
    check("mr_resp_empty", 1, mst_if.resp_ready[1], 1'b1);
    check("mr_cnt_cleared", 1, outstanding[1], 0);
    check("mr_err_cleared", 1, err, 4'h0);
    rst = 1'b0;
    for (int t = 0; t < 5; t++) step();
    check("mr_no_stale_req", 1, dlv_n[1], base_q);
    check("mr_no_stale_resp", 1, rsp_dlv[1], base_r);
    check("mr_valid_idle", 1, mst_if.req_valid, 4'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/tcdm_link_cut.md
TCDM_LINK_CUT -- requirements
Module: tcdm_link_cut

Interface
REQ-001 SHALL have parameter NumPorts, default 4, meaning the number of parallel tile links carried per inter-group direction (NumTilesPerGroup).
REQ-002 SHALL have parameter MaxOutstanding, default 8, meaning the maximum number of unanswered requests per port.
REQ-003 SHALL have parameter req_t, default tcdm_slave_req_t, meaning the request payload type.
REQ-004 SHALL have parameter resp_t, default tcdm_master_resp_t, meaning the response payload type.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  clock; all state updates on its rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 slv_req_i  in  NumPorts x req_t  request from the sending group master port.
REQ-009 slv_req_valid_i / slv_req_ready_o  in / out  NumPorts each  request handshake, sending side.
REQ-010 slv_resp_o  out  NumPorts x resp_t  response back to the sending group.
REQ-011 slv_resp_valid_o / slv_resp_ready_i  out / in  NumPorts each  response handshake, sending side.
REQ-012 mst_req_o  out  NumPorts x req_t  request toward the receiving group slave port.
REQ-013 mst_req_valid_o / mst_req_ready_i  out / in  NumPorts each  request handshake, receiving side.
REQ-014 mst_resp_i  in  NumPorts x resp_t  response from the receiving group.
REQ-015 mst_resp_valid_i / mst_resp_ready_o  in / out  NumPorts each  response handshake, receiving side.
REQ-016 outstanding_o  out  NumPorts x $clog2(MaxOutstanding+1)  per-port count of unanswered requests.
REQ-017 err_o  out  NumPorts  sticky per-port response-underflow flag.

Function
REQ-018 A transfer SHALL occur on a channel exactly when valid and ready are both high at a rising clk_i edge.
REQ-019 Each port SHALL hold one independent 2-entry FIFO in the request direction and one in the response direction, giving 2*NumPorts buffers.
REQ-020 Each buffer SHALL have the states EMPTY, ONE and TWO; a push alone moves it up one state, a pop alone moves it down one state, and a simultaneous push and pop leaves the state unchanged.
REQ-021 A buffer's input ready SHALL be high iff its state is not TWO, and its output valid SHALL be high iff its state is not EMPTY.
REQ-022 Ready and valid outputs SHALL be driven only from registers; there SHALL be no combinational path from any ready input or valid input to any output.
REQ-023 Latency from input handshake to output valid SHALL be exactly 1 cycle.
REQ-024 With the downstream continuously ready, each buffer SHALL sustain 1 transfer per cycle.
REQ-025 Payload order SHALL be preserved per port and per direction.
REQ-026 Payload SHALL pass through bit-exact.
REQ-027 outstanding_o[p] SHALL increment on a slv_req handshake and decrement on a slv_resp handshake, and SHALL be unchanged when both occur in the same cycle.
REQ-028 When outstanding_o[p] equals MaxOutstanding, slv_req_ready_o[p] SHALL be 0 regardless of buffer state.
REQ-029 A slv_resp handshake while outstanding_o[p] is 0 SHALL leave the counter at 0 and set err_o[p] to 1 until reset.
REQ-030 Every request, whether read or write, SHALL be accounted as expecting exactly one response.

Reset
REQ-031 While rst_i is high, all buffers SHALL be forced to EMPTY and all valid outputs SHALL be 0.
REQ-032 While rst_i is high, slv_req_ready_o and mst_resp_ready_o SHALL be 1 (state EMPTY).
REQ-033 While rst_i is high, outstanding_o SHALL be 0, err_o SHALL be 0, and payload registers SHALL be '0.
REQ-034 A reset asserted mid-operation SHALL discard buffered entries without emitting them; no partial handshake SHALL complete in that cycle.

Structure
REQ-035 req_t and resp_t SHALL come from mempool_pkg, and MaxOutstanding's default SHALL be a mempool_pkg constant.
REQ-036 The 2-entry buffer SHALL be a single sub-module, tcdm_spill_fifo, parameterised by payload type and instantiated 2*NumPorts times.
REQ-037 The outstanding counter and underflow flag SHALL live in tcdm_link_cut.

Verification
REQ-038 Reset scenario: after a 2-cycle rst_i pulse -> all valids 0, both input-side readys 1, outstanding_o 0, err_o 0.
REQ-039 Streaming scenario: 16 back-to-back requests on port 0 with mst_req_ready_i held 1 -> mst_req_valid_o rises 1 cycle after the first handshake, 16 in-order beats are delivered with no bubbles, and outstanding_o[0] reaches 8 and then stalls.
REQ-040 Backpressure scenario: mst_req_ready_i=0 with 3 offered requests -> 2 accepted, slv_req_ready_o drops the cycle after the second handshake, and releasing ready drains entries A then B.
REQ-041 Outstanding-limit scenario: 8 requests with no response -> slv_req_ready_o[p]=0; one response plus a simultaneous new request -> counter stays at 8.
REQ-042 Underflow scenario: a response injected on port 2 with counter 0 -> err_o[2]=1 and stays 1; other ports are unaffected.
REQ-043 Mid-reset scenario: reset applied with both buffers in TWO -> next cycle states EMPTY and no stale beat is emitted after release.
